// File: rtl/platform_boot_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : platform_boot_ctrl_if
// Purpose  : Host, ROM-load and run-phase signal bundle for platform_boot_ctrl.
//            Optional ld_last signal present when ZERO_FILL_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface platform_boot_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              abort;
    logic [7:0]        ld_data;
    logic              ld_valid;
    logic              ld_ready;
`ifdef ZERO_FILL_EN
    logic              ld_last;
`endif
    logic [ADDR_W-1:0] sw_addr;
    logic [7:0]        sw_din;
    logic              we_n;
    logic              mode;
    logic              plat_rst;
    logic              din_req;
    logic [31:0]       din;
    logic              din_rdy;
    logic [31:0]       host_din;
    logic              host_din_valid;
    logic              host_din_ready;
    logic [31:0]       dout;
    logic              dout_rdy;
    logic [31:0]       host_dout;
    logic              host_dout_valid;
    logic              host_dout_ready;
    logic              busy;
    logic              ovf;

    modport master (
        input  start, abort, ld_data, ld_valid,
`ifdef ZERO_FILL_EN
        input  ld_last,
`endif
        input  din_req, host_din, host_din_valid, dout, dout_rdy, host_dout_ready,
        output ld_ready, sw_addr, sw_din, we_n, mode, plat_rst, din, din_rdy,
        output host_din_ready, host_dout, host_dout_valid, busy, ovf
    );

    modport slave (
        output start, abort, ld_data, ld_valid,
`ifdef ZERO_FILL_EN
        output ld_last,
`endif
        output din_req, host_din, host_din_valid, dout, dout_rdy, host_dout_ready,
        input  ld_ready, sw_addr, sw_din, we_n, mode, plat_rst, din, din_rdy,
        input  host_din_ready, host_dout, host_dout_valid, busy, ovf
    );
endinterface
`default_nettype wire

// File: rtl/platform_boot_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : platform_boot_ctrl
// Purpose  : Streams a program image into the platform ROM, releases platform
//            reset, then bridges the din/dout handshakes to host streams.
//            Define ZERO_FILL_EN to add ld_last with zero-fill of the ROM tail.
// Revision : 1.0 - initial release
// ============================================================================
module platform_boot_ctrl #(
    parameter int ROM_SIZE       = 16384,
    parameter int ADDR_W         = 14,
    parameter int RUN_RST_CYCLES = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    platform_boot_ctrl_if.master  bus
);
    localparam int                c_PW         = (RUN_RST_CYCLES > 1) ? $clog2(RUN_RST_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] c_LAST       = ADDR_W'(ROM_SIZE - 1);
    localparam logic [c_PW-1:0]   c_PRST_LAST  = c_PW'(RUN_RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_FILL = 3'd2,
        S_LEND = 3'd3,
        S_PRST = 3'd4,
        S_RUN  = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [c_PW-1:0]   r_prst_cnt;
    logic [ADDR_W-1:0] r_sw_addr;
    logic [7:0]        r_sw_din;
    logic              r_we_n;
    logic [31:0]       r_din;
    logic              r_din_rdy;
    logic              r_dout_rdy_q;
    logic [31:0]       r_host_dout;
    logic              r_host_dout_valid;
    logic              r_ovf;

    logic              w_ld_ready;
    logic              w_mode;
    logic              w_plat_rst;
    logic              w_busy;
    logic              w_host_din_ready;
    logic              w_accept;
    logic              w_last;
    logic              w_rise;

`ifdef ZERO_FILL_EN
    assign w_last = bus.ld_last;
`else
    assign w_last = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort overrides every transition and also blocks new handshakes that cycle.
    always_comb begin
        w_next           = r_state;
        w_ld_ready       = 1'b0;
        w_mode           = 1'b1;
        w_plat_rst       = 1'b1;
        w_busy           = 1'b1;
        w_host_din_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) w_next = S_LOAD;
            end
            S_LOAD: begin
                w_ld_ready = !bus.abort;
                if (bus.ld_valid) begin
                    if (r_cnt == c_LAST) w_next = S_LEND;
                    else if (w_last)     w_next = S_FILL;
                end
            end
            S_FILL: begin
                if (r_cnt == c_LAST) w_next = S_LEND;
            end
            S_LEND: begin
                w_next = S_PRST;
            end
            S_PRST: begin
                w_mode = 1'b0;
                if (r_prst_cnt == c_PRST_LAST) w_next = S_RUN;
            end
            S_RUN: begin
                w_mode           = 1'b0;
                w_plat_rst       = 1'b0;
                w_host_din_ready = bus.din_req && !r_din_rdy && !bus.abort;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.abort) w_next = S_IDLE;
    end

    assign w_accept = w_ld_ready && bus.ld_valid;
    assign w_rise   = bus.dout_rdy && !r_dout_rdy_q && (r_state == S_RUN) && !bus.abort;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt      <= '0;
            r_prst_cnt <= '0;
            r_sw_addr  <= '0;
            r_sw_din   <= '0;
            r_we_n     <= 1'b1;
            r_din      <= '0;
            r_din_rdy  <= 1'b0;
        end else if (bus.abort) begin
            r_cnt      <= '0;
            r_prst_cnt <= '0;
            r_sw_addr  <= '0;
            r_sw_din   <= '0;
            r_we_n     <= 1'b1;
            r_din      <= '0;
            r_din_rdy  <= 1'b0;
        end else begin
            r_we_n <= 1'b1;
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end
            if (w_accept) begin
                r_sw_addr <= r_cnt;
                r_sw_din  <= bus.ld_data;
                r_we_n    <= 1'b0;
                r_cnt     <= r_cnt + 1'b1;
            end else if (r_state == S_FILL) begin
                r_sw_addr <= r_cnt;
                r_sw_din  <= 8'h00;
                r_we_n    <= 1'b0;
                r_cnt     <= r_cnt + 1'b1;
            end

            if (r_state == S_PRST) r_prst_cnt <= r_prst_cnt + 1'b1;
            else                   r_prst_cnt <= '0;

            if (r_state != S_RUN) begin
                r_din_rdy <= 1'b0;
            end else if (w_host_din_ready && bus.host_din_valid) begin
                r_din     <= bus.host_din;
                r_din_rdy <= 1'b1;
            end else if (r_din_rdy && !bus.din_req) begin
                r_din_rdy <= 1'b0;
            end
        end
    end

    // Result buffer survives abort; only reset clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dout_rdy_q      <= 1'b0;
            r_host_dout       <= '0;
            r_host_dout_valid <= 1'b0;
            r_ovf             <= 1'b0;
        end else begin
            r_dout_rdy_q <= bus.dout_rdy;
            if (w_rise) begin
                if (!r_host_dout_valid || bus.host_dout_ready) begin
                    r_host_dout       <= bus.dout;
                    r_host_dout_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
            end else if (r_host_dout_valid && bus.host_dout_ready) begin
                r_host_dout_valid <= 1'b0;
            end
        end
    end

    assign bus.ld_ready        = w_ld_ready;
    assign bus.sw_addr         = r_sw_addr;
    assign bus.sw_din          = r_sw_din;
    assign bus.we_n            = r_we_n;
    assign bus.mode            = w_mode;
    assign bus.plat_rst        = w_plat_rst;
    assign bus.din             = r_din;
    assign bus.din_rdy         = r_din_rdy;
    assign bus.host_din_ready  = w_host_din_ready;
    assign bus.host_dout       = r_host_dout;
    assign bus.host_dout_valid = r_host_dout_valid;
    assign bus.busy            = w_busy;
    assign bus.ovf             = r_ovf;

endmodule
`default_nettype wire
